de10_nano_qsys_paddle_in: RTL and testbench

//   Avalon-MM slave input PIO: samples a 16-bit external bus (paddle/ADC position) into the Qsys domain.

---
 rtl/de10_nano_pio_pkg.sv | 12 +
 rtl/de10_nano_qsys_paddle_in_if.sv | 11 +
 rtl/pio_debounce.sv | 38 +++
 rtl/de10_nano_qsys_paddle_in.sv | 106 ++++++++++
 tb/tb_de10_nano_qsys_paddle_in.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/de10_nano_pio_pkg.sv
// Shared register map and edge-type encodings for the DE10-Nano Qsys PIO blocks.
package de10_nano_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/de10_nano_qsys_paddle_in_if.sv
// Avalon-MM slave bus of the paddle input PIO (fixed read latency 1, no wait states).
interface de10_nano_qsys_paddle_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_debounce.sv
// Per-bit debounce: output follows input after DB_CYCLES+1 consecutive disagreeing samples.
// Latency DB_CYCLES+1 clk; 'load' copies the input straight through (used while priming).
module pio_debounce #(
    parameter int WIDTH     = 16,
    parameter int DB_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt;
        logic          q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
                q   <= 1'b0;
            end else if (load) begin
                cnt <= '0;
                q   <= din[i];
            end else if (din[i] == q) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES)) begin
                cnt <= '0;
                q   <= din[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign dout[i] = q;
    end
endmodule

// File: rtl/de10_nano_qsys_paddle_in.sv
// Avalon-MM input PIO: synchronised 16-bit paddle bus, per-bit edge capture (W1C), masked level IRQ.
// Latency in_port -> edge_cap 3 clk (DB_CYCLES+4 with PADDLE_IN_DEBOUNCE_EN); read latency 1; never stalls.
module de10_nano_qsys_paddle_in
    import de10_nano_pio_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int EDGE_TYPE = 0,
    parameter int DB_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    de10_nano_qsys_paddle_in_if.slave    bus,
    input  logic [WIDTH-1:0]             in_port,
    output logic                         irq
);
    if (WIDTH < 1 || WIDTH > 32 || DB_CYCLES < 1) begin : g_param_check
        $error("de10_nano_qsys_paddle_in: WIDTH must be 1..32 and DB_CYCLES >= 1");
    end

`ifdef PADDLE_IN_DEBOUNCE_EN
    localparam int INIT_LEN = 4;
`else
    localparam int INIT_LEN = 3;
`endif

    logic [WIDTH-1:0]    s1, s2, val, prev;
    logic [WIDTH-1:0]    edge_cap, irq_mask, edge_det, clr;
    logic [INIT_LEN-1:0] init_sr;
    logic                primed;
    logic                wr, rd;
    logic [31:0]         rd_mux;

`ifdef PADDLE_IN_DEBOUNCE_EN
    pio_debounce #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (~init_sr[2]),
        .din     (s2),
        .dout    (val)
    );
`else
    assign val = s2;
`endif

    // init_sr tracks how far the sampling pipeline has filled since reset; edges
    // are only reported once prev holds a real sample, so reset never fakes an edge.
    assign primed = init_sr[INIT_LEN-1];
    assign wr     = bus.chipselect & ~bus.write_n;
    assign rd     = bus.chipselect &  bus.write_n;

    always_comb begin
        edge_det = '0;
        if (primed) begin
            if (EDGE_TYPE == EDGE_FALL)
                edge_det = ~val & prev;
            else if (EDGE_TYPE == EDGE_ANY)
                edge_det = val ^ prev;
            else
                edge_det = val & ~prev;
        end
    end

    always_comb begin
        clr = '0;
        if (wr && bus.address == ADDR_EDGECAP)
            clr = bus.writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = val;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1           <= '0;
            s2           <= '0;
            prev         <= '0;
            init_sr      <= '0;
            edge_cap     <= '0;
            irq_mask     <= '0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            s1       <= in_port;
            s2       <= s1;
            prev     <= val;
            init_sr  <= {init_sr[INIT_LEN-2:0], 1'b1};
            // A fresh edge beats a same-cycle clear so no event is ever dropped.
            edge_cap <= (edge_cap & ~clr) | edge_det;
            if (wr && bus.address == ADDR_IRQMASK)
                irq_mask <= bus.writedata[WIDTH-1:0];
            if (rd)
                bus.readdata <= rd_mux;
            irq      <= |(edge_cap & irq_mask);
        end
    end
endmodule

// File: tb/tb_de10_nano_qsys_paddle_in.sv
// Directed bench: rising-edge instance (dut_a) and any-edge instance (dut_b) of the paddle input PIO.
module tb_de10_nano_qsys_paddle_in;
    import de10_nano_pio_pkg::*;

`ifdef PADDLE_IN_DEBOUNCE_EN
    localparam int DB  = 8;
    localparam int LAT = 4 + DB;
`else
    localparam int DB  = 1024;
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_a, in_b;
    logic        irq_a, irq_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    de10_nano_qsys_paddle_in_if bus_a ();
    de10_nano_qsys_paddle_in_if bus_b ();

    de10_nano_qsys_paddle_in #(.WIDTH(16), .EDGE_TYPE(EDGE_RISE), .DB_CYCLES(DB)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_a), .irq(irq_a));

    de10_nano_qsys_paddle_in #(.WIDTH(16), .EDGE_TYPE(EDGE_ANY), .DB_CYCLES(DB)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_b), .irq(irq_b));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.address = 2'd0; bus_a.writedata = '0;
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.address = 2'd0; bus_b.writedata = '0;
    endtask

    task automatic bus_write(input bit sel, input logic [1:0] a, input logic [31:0] d);
        if (!sel) begin
            bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        end else begin
            bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        end
        tick(1);
        bus_idle();
    endtask

    task automatic bus_read(input bit sel, input logic [1:0] a, output logic [31:0] d);
        if (!sel) begin
            bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
        end else begin
            bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
        end
        tick(1);
        d = sel ? bus_b.readdata : bus_a.readdata;
        bus_idle();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus_idle();
        reset_n = 1'b0;
        in_a = 16'hFFFF;
        in_b = 16'hFFFF;
        tick(3);
        reset_n = 1'b1;
        tick(LAT + 5);
        checks++; if (bus_a.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected %h", bus_a.readdata, 32'h0); end
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_a); end
        checks++; if (dut_a.edge_cap !== 16'h0) begin errors++; $display("FAIL reset_edgecap_rise: got %h expected 0000", dut_a.edge_cap); end
        checks++; if (dut_b.edge_cap !== 16'h0) begin errors++; $display("FAIL reset_edgecap_any: got %h expected 0000", dut_b.edge_cap); end
        bus_read(1'b0, ADDR_EDGECAP, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_read_edgecap: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_data_read();
        logic [31:0] d;
        in_a = 16'h1234;
        tick(LAT);
        bus_read(1'b0, ADDR_DATA, d);
        checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL data_read: got %h expected %h", d, 32'h0000_1234); end
        checks++; if (dut_a.edge_cap !== 16'h0) begin errors++; $display("FAIL falling_ignored: got %h expected 0000", dut_a.edge_cap); end
        bus_write(1'b0, ADDR_DATA, 32'h0000_FFFF);
        bus_read(1'b0, 2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h expected %h", d, 32'h0); end
        bus_read(1'b0, ADDR_DATA, d);
        checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL data_write_ignored: got %h expected %h", d, 32'h0000_1234); end
        tick(3);
        checks++; if (bus_a.readdata !== 32'h0000_1234) begin errors++; $display("FAIL readdata_hold: got %h expected %h", bus_a.readdata, 32'h0000_1234); end
        bus_write(1'b0, ADDR_EDGECAP, 32'h0000_FFFF);
    endtask

    task automatic test_irqmask_reg();
        logic [31:0] d;
        bus_write(1'b0, ADDR_IRQMASK, 32'hABCD_0001);
        bus_read(1'b0, ADDR_IRQMASK, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL irqmask_rw: got %h expected %h", d, 32'h0000_0001); end
    endtask

    task automatic test_rise_irq();
        logic [31:0] d;
        in_a = 16'h1235;
        tick(LAT - 1);
        checks++; if (dut_a.edge_cap !== 16'h0) begin errors++; $display("FAIL rise_early: got %h expected 0000", dut_a.edge_cap); end
        tick(1);
        checks++; if (dut_a.edge_cap !== 16'h0001) begin errors++; $display("FAIL rise_capture: got %h expected 0001", dut_a.edge_cap); end
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_not_yet: got %b expected 0", irq_a); end
        tick(1);
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", irq_a); end
        bus_read(1'b0, ADDR_EDGECAP, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL edgecap_read: got %h expected %h", d, 32'h0000_0001); end
        bus_write(1'b0, ADDR_EDGECAP, 32'h0000_0001);
        checks++; if (dut_a.edge_cap !== 16'h0) begin errors++; $display("FAIL w1c_clear: got %h expected 0000", dut_a.edge_cap); end
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_hold_after_clear: got %b expected 1", irq_a); end
        tick(1);
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_deassert: got %b expected 0", irq_a); end
    endtask

    task automatic test_collision();
        in_a = 16'h1234;
        tick(LAT + 1);
        checks++; if (dut_a.edge_cap !== 16'h0) begin errors++; $display("FAIL fall_no_capture: got %h expected 0000", dut_a.edge_cap); end
        in_a = 16'h1235;
        tick(LAT - 1);
        bus_a.address = ADDR_EDGECAP; bus_a.writedata = 32'h1; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        tick(1);
        bus_idle();
        checks++; if (dut_a.edge_cap !== 16'h0001) begin errors++; $display("FAIL collision_set_wins: got %h expected 0001", dut_a.edge_cap); end
        tick(1);
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL collision_irq: got %b expected 1", irq_a); end
        tick(1);
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL collision_irq_stays: got %b expected 1", irq_a); end
    endtask

    task automatic test_any_edge();
        logic [31:0] d;
        in_b = 16'h0000;
        tick(LAT + 1);
        bus_write(1'b1, ADDR_EDGECAP, 32'h0000_FFFF);
        bus_read(1'b1, ADDR_EDGECAP, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL any_cleared: got %h expected %h", d, 32'h0); end
        in_b = 16'h0020;
        tick(LAT + 1);
        in_b = 16'h0000;
        tick(LAT + 1);
        bus_read(1'b1, ADDR_EDGECAP, d);
        checks++; if (d !== 32'h0000_0020) begin errors++; $display("FAIL any_edge_bit5: got %h expected %h", d, 32'h0000_0020); end
        checks++; if (irq_b !== 1'b0) begin errors++; $display("FAIL any_masked_irq: got %b expected 0", irq_b); end
        bus_write(1'b1, ADDR_IRQMASK, 32'h0000_0020);
        checks++; if (irq_b !== 1'b0) begin errors++; $display("FAIL mask_irq_early: got %b expected 0", irq_b); end
        tick(1);
        checks++; if (irq_b !== 1'b1) begin errors++; $display("FAIL mask_irq: got %b expected 1", irq_b); end
    endtask

    task automatic test_midreset();
        reset_n = 1'b0;
        #1;
        checks++; if (irq_b !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq_b); end
        checks++; if (dut_b.edge_cap !== 16'h0) begin errors++; $display("FAIL midreset_edgecap: got %h expected 0000", dut_b.edge_cap); end
        checks++; if (bus_a.readdata !== 32'h0) begin errors++; $display("FAIL midreset_readdata: got %h expected %h", bus_a.readdata, 32'h0); end
        tick(2);
        reset_n = 1'b1;
        tick(LAT + 5);
        checks++; if (dut_a.edge_cap !== 16'h0) begin errors++; $display("FAIL post_reset_no_edge: got %h expected 0000", dut_a.edge_cap); end
    endtask

`ifdef PADDLE_IN_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] d;
        in_a = 16'h123D;
        tick(5);
        in_a = 16'h1235;
        tick(20);
        bus_read(1'b0, ADDR_DATA, d);
        checks++; if (d !== 32'h0000_1235) begin errors++; $display("FAIL glitch_data: got %h expected %h", d, 32'h0000_1235); end
        checks++; if (dut_a.edge_cap[3] !== 1'b0) begin errors++; $display("FAIL glitch_edge: got %b expected 0", dut_a.edge_cap[3]); end
        in_a = 16'h123D;
        tick(12);
        in_a = 16'h1235;
        tick(20);
        checks++; if (dut_a.edge_cap[3] !== 1'b1) begin errors++; $display("FAIL pulse_edge: got %b expected 1", dut_a.edge_cap[3]); end
    endtask
`endif

    initial begin
        test_reset();
        test_data_read();
        test_irqmask_reg();
        test_rise_irq();
        test_collision();
        test_any_edge();
        test_midreset();
`ifdef PADDLE_IN_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
